// File: rtl/conv_frame_driver_if.sv
// Host-load and conv-core stream signals seen by conv_frame_driver.
// The master modport is the driver side; the slave modport is the host/core side.
interface conv_frame_driver_if #(
  parameter int T = 20
);
  logic [T-1:0] ld_data;
  logic         ld_valid;
  logic         ld_ready;
  logic [T-1:0] x_data;
  logic         x_valid;
  logic         x_ready;
  logic [T-1:0] y_data;
  logic         y_valid;
  logic         y_ready;

  modport master (
    input  ld_data, ld_valid, x_ready, y_data, y_valid,
    output ld_ready, x_data, x_valid, y_ready
  );

  modport slave (
    output ld_data, ld_valid, x_ready, y_data, y_valid,
    input  ld_ready, x_data, x_valid, y_ready
  );
endinterface

// File: rtl/conv_frame_driver.sv
// Buffers one frame of host samples, streams it to a conv core as x, and
// captures the core's NY results into a buffer exposed on a registered read port.
module conv_frame_driver #(
  parameter  int T      = 20,
  parameter  int SIZE_X = 16,
  parameter  int SIZE_F = 4,
  localparam int NY     = SIZE_X - SIZE_F + 1,
  localparam int RA_W   = $clog2(NY)
) (
  input  logic             clk,
  input  logic             reset,
  conv_frame_driver_if.master bus,
  input  logic             start,
  input  logic             clear,
  input  logic [RA_W-1:0]  rd_addr,
  output logic [T-1:0]     rd_data,
  output logic             busy,
  output logic             done
);

  localparam int XC_W = $clog2(SIZE_X + 1);
  localparam int YC_W = $clog2(NY + 1);
  localparam int XI_W = $clog2(SIZE_X);
  localparam int YI_W = $clog2(NY);

  localparam logic [XC_W-1:0] X_FULL = XC_W'(SIZE_X);
  localparam logic [YC_W-1:0] Y_FULL = YC_W'(NY);
  localparam logic [RA_W:0]   RD_LIM = (RA_W + 1)'(NY);

  typedef enum logic [1:0] {S_LOAD, S_SEND, S_RECV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [XC_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [XC_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic [YC_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [T-1:0]      rd_data_q, rd_data_d;
  logic [T-1:0]      x_buf_q [SIZE_X];
  logic [T-1:0]      x_buf_d [SIZE_X];
  logic [T-1:0]      y_buf_q [NY];
  logic [T-1:0]      y_buf_d [NY];

  logic              ld_ready, x_valid, y_ready;
  logic [T-1:0]      x_data;

  // NOTE: every signal gets a default at the top of always_comb (blocking '=');
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    x_buf_d  = x_buf_q;
    y_buf_d  = y_buf_q;
    ld_ready = 1'b0;
    x_valid  = 1'b0;
    x_data   = '0;
    y_ready  = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        ld_ready = (ld_cnt_q < X_FULL);
        if (bus.ld_valid && ld_ready) begin
          x_buf_d[ld_cnt_q[XI_W-1:0]] = bus.ld_data;
          ld_cnt_d = ld_cnt_q + XC_W'(1);
        end
        if (start && (ld_cnt_q == X_FULL)) begin
          state_d  = S_SEND;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
        end
      end

      S_SEND, S_RECV: begin
        // Results may arrive while the frame is still being sent.
        y_ready = (rx_cnt_q < Y_FULL);
        if (bus.y_valid && y_ready) begin
          y_buf_d[rx_cnt_q[YI_W-1:0]] = bus.y_data;
          rx_cnt_d = rx_cnt_q + YC_W'(1);
        end
        if (state_q == S_SEND) begin
          x_valid = 1'b1;
          x_data  = x_buf_q[tx_cnt_q[XI_W-1:0]];
          if (bus.x_ready) tx_cnt_d = tx_cnt_q + XC_W'(1);
        end
        // Final x and final y landing together go straight to DONE.
        if ((tx_cnt_d == X_FULL) && (rx_cnt_d == Y_FULL)) state_d = S_DONE;
        else if (tx_cnt_d == X_FULL)                       state_d = S_RECV;
      end

      S_DONE: begin
        if (clear) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < RD_LIM) rd_data_d = y_buf_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LOAD;
      ld_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: the sample/result buffers are not reset; their contents only matter
  // once written, and leaving them out keeps them plain storage.
  always_ff @(posedge clk) begin
    x_buf_q <= x_buf_d;
    y_buf_q <= y_buf_d;
  end

  assign bus.ld_ready = ld_ready;
  assign bus.x_valid  = x_valid;
  assign bus.x_data   = x_data;
  assign bus.y_ready  = y_ready;
  assign rd_data      = rd_data_q;
  assign busy         = (state_q == S_SEND) || (state_q == S_RECV);
  assign done         = (state_q == S_DONE);

endmodule

// File: doc/conv_frame_driver.md
Name: conv_frame_driver

Overview:
- Stream-side partner of the conv_<X>_<F>_<T>_<P> cores.
- Buffers one frame of SIZE_X input samples written by a host, then transmits them as the conv core's x stream (x_data/x_valid/x_ready).
- Captures the SIZE_X-SIZE_F+1 results the core returns on its y stream (y_data/y_valid/y_ready) and exposes them on a registered read port.
- Used as the on-chip source/sink around a conv instance for system bring-up and regression.

Parameters:
- T, 20, sample and result width in bits.
- SIZE_X, 16, samples per frame.
- SIZE_F, 4, filter length; sets the result count NY = SIZE_X-SIZE_F+1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ld_data  in  T  host sample to buffer.
- ld_valid  in  1  ld_data is valid.
- ld_ready  out  1  driver accepts a host sample.
- start  in  1  one-cycle request to begin transmitting the frame.
- clear  in  1  return from DONE to LOAD.
- x_data  out  T  sample to the conv core.
- x_valid  out  1  x_data is valid.
- x_ready  in  1  conv core accepts x_data.
- y_data  in  T  result from the conv core.
- y_valid  in  1  y_data is valid.
- y_ready  out  1  driver accepts a result.
- rd_addr  in  clog2(NY)  result index to read.
- rd_data  out  T  result at rd_addr, registered.
- busy  out  1  high in SEND or RECV.
- done  out  1  high in DONE.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset takes priority over everything, including mid-frame. On the edge where reset=1:
  - state=LOAD; ld_cnt, tx_cnt, rx_cnt all 0.
  - Effective outputs: ld_ready=1, x_valid=0, y_ready=0, busy=0, done=0, rd_data=0.
  - Buffer contents are don't-care.
- Storage:
  - x_buf: SIZE_X x T register array, read combinationally so there is no read bubble.
  - y_buf: NY x T register array.
- State machine: LOAD -> SEND -> RECV -> DONE -> LOAD.
- LOAD:
  - ld_ready = (ld_cnt < SIZE_X).
  - On ld_valid && ld_ready: x_buf[ld_cnt] <= ld_data and ld_cnt++.
  - ld_ready drops combinationally once ld_cnt == SIZE_X.
  - start is honoured only when ld_cnt == SIZE_X; then next state is SEND and tx_cnt=0. Otherwise start is ignored.
  - In LOAD: x_valid=0, y_ready=0.
- SEND:
  - x_valid=1, x_data = x_buf[tx_cnt].
  - A transfer occurs when x_valid && x_ready; then tx_cnt++.
  - While x_ready=0, x_data and x_valid hold stable.
  - After transfer number SIZE_X (tx_cnt == SIZE_X-1 at the handshake), x_valid is 0 from the next cycle and state moves to RECV.
  - No gap between back-to-back transfers: one sample per cycle when x_ready stays high.
- Result capture (SEND and RECV):
  - y_ready = (rx_cnt < NY).
  - On y_valid && y_ready: y_buf[rx_cnt] <= y_data and rx_cnt++.
  - Results arriving during SEND are accepted.
  - The driver stores y_data unmodified; any ReLU is applied by the core.
- Transition to DONE happens when tx_cnt has reached SIZE_X and rx_cnt has reached NY. This includes the case where the final x and the final y handshakes land in the same cycle.
- DONE:
  - done=1, y_ready=0, x_valid=0.
  - Further y_valid is ignored and not stored.
  - clear -> LOAD with ld_cnt, tx_cnt, rx_cnt reset to 0.
  - start in DONE is ignored.
- Read port: every cycle, rd_data <= y_buf[rd_addr] (1-cycle latency). It is valid in any state; content is defined only for indices already captured. rd_addr >= NY returns 0.
- busy = state is SEND or RECV.
- clear is ignored outside DONE.
- ld_valid is ignored outside LOAD.

Test Plan:
- Load samples 1..16 with ld_valid held high, pulse start, keep x_ready=1 -> x_valid high for exactly 16 consecutive cycles, x_data = 1,2,...,16, then x_valid=0 and busy=1 (state RECV).
- During SEND, toggle x_ready 1,0,0,1,... -> each sample held stable while x_ready=0; total of 16 transfers, in order, with no duplicates or skips.
- Present 13 results 100..112 with y_valid=1, first arriving during SEND -> all captured; done=1 the cycle after the 13th handshake; a 14th y_valid is not accepted (y_ready=0). Reading rd_addr=0..12 gives 100..112 one cycle later.
- Pulse start after loading only 10 samples -> state stays LOAD, x_valid=0; load 6 more, pulse start -> SEND begins with x_data=sample 0.
- Assert reset after 7 x transfers -> next cycle: ld_ready=1, x_valid=0, y_ready=0, busy=0, done=0; a fresh load/start cycle completes correctly.
- In DONE: pulse start -> no change; pulse clear -> LOAD, ld_ready=1, a full second frame runs end to end.
